// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage definitions: ALU function codes, jXX/cmovXX
// condition codes, the condition-code register layout and its reset value.
// Imported by the CC/condition unit and by the fetch-stage predictor check.
package y86_pkg;

    // ALU function codes (ifun field of OPq)
    localparam logic [3:0] ALUFUN_ADD = 4'd0;
    localparam logic [3:0] ALUFUN_SUB = 4'd1;
    localparam logic [3:0] ALUFUN_AND = 4'd2;
    localparam logic [3:0] ALUFUN_XOR = 4'd3;

    // Branch / conditional-move condition codes
    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_LE     = 4'd1;
    localparam logic [3:0] COND_L      = 4'd2;
    localparam logic [3:0] COND_E      = 4'd3;
    localparam logic [3:0] COND_NE     = 4'd4;
    localparam logic [3:0] COND_GE     = 4'd5;
    localparam logic [3:0] COND_G      = 4'd6;

    // Condition-code register, packed MSB-first as {ZF,SF,OF}
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = 3'b100;

endpackage

// File: rtl/y86_cond_eval.sv
// Condition evaluator: maps (cc, ifun) to the jXX/cmovXX taken flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state. Ports: cc_i (flags), ifun_i (condition), cnd_o.
module y86_cond_eval
    import y86_pkg::*;
(
    input  cc_t        cc_i,
    input  logic [3:0] ifun_i,
    output logic       cnd_o
);

    logic lt;

    // Signed "less than" after a compare is SF xor OF.
    assign lt = cc_i.sf ^ cc_i.of;

    always_comb begin
        cnd_o = 1'b0;
        case (ifun_i)
            COND_ALWAYS: cnd_o = 1'b1;
            COND_LE:     cnd_o = lt | cc_i.zf;
            COND_L:      cnd_o = lt;
            COND_E:      cnd_o = cc_i.zf;
            COND_NE:     cnd_o = ~cc_i.zf;
            COND_GE:     cnd_o = ~lt;
            COND_G:      cnd_o = ~lt & ~cc_i.zf;
            default:     cnd_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_cc_cond_unit.sv
// Execute-stage CC register, jXX/cmovXX condition evaluation and E->M cnd/valid register.
// Latency: e_cnd combinational from registered cc; cc, M_cnd, M_valid update 1 cycle later.
// Backpressure: m_stall holds E->M (stall beats bubble); CC writes ignore m_stall.
// Ports: clk/rst_n; E-stage ALU operands/result and control; M/W exception flags;
// m_stall/m_bubble; outputs e_cnd, cc {ZF,SF,OF}, M_cnd, M_valid.
// Optional build macro CC_PERF_EN adds saturating counters perf_cc_writes and perf_cnd_taken.
module y86_cc_cond_unit
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e_valid,
    input  logic        e_set_cc,
    input  logic [3:0]  e_alufun,
    input  logic [63:0] e_vala,
    input  logic [63:0] e_valb,
    input  logic [63:0] e_valE,
    input  logic [3:0]  e_ifun,
    input  logic        m_stat_bad,
    input  logic        w_stat_bad,
    input  logic        m_stall,
    input  logic        m_bubble,
    output logic        e_cnd,
`ifdef CC_PERF_EN
    output logic [31:0] perf_cc_writes,
    output logic [31:0] perf_cnd_taken,
`endif
    output logic [2:0]  cc,
    output logic        M_cnd,
    output logic        M_valid
);

    cc_t  cc_q, cc_d;
    cc_t  flags;
    logic cc_we;
    logic m_valid_q, m_valid_d;
    logic m_cnd_q, m_cnd_d;
    logic m_load;

    // Flag generation from the ALU result and operands
    always_comb begin
        flags.zf = (e_valE == 64'd0);
        flags.sf = e_valE[63];
        flags.of = 1'b0;
        case (e_alufun)
            ALUFUN_ADD: flags.of = (e_vala[63] == e_valb[63]) & (e_valE[63] != e_vala[63]);
            ALUFUN_SUB: flags.of = (e_vala[63] != e_valb[63]) & (e_valE[63] != e_valb[63]);
            default:    flags.of = 1'b0;
        endcase
    end

    // An exception further down the pipe squashes the flag update of a
    // younger OPq so the architectural CC matches precise-exception order.
    assign cc_we = e_valid & e_set_cc & ~m_stat_bad & ~w_stat_bad;
    assign cc_d  = cc_we ? flags : cc_q;

    // Condition uses the registered flags only, never this cycle's flags.
    y86_cond_eval u_cond_eval (
        .cc_i   (cc_q),
        .ifun_i (e_ifun),
        .cnd_o  (e_cnd)
    );

    assign m_load = ~m_stall & ~m_bubble;

    always_comb begin
        m_valid_d = m_valid_q;
        m_cnd_d   = m_cnd_q;
        if (m_stall) begin
            m_valid_d = m_valid_q;
            m_cnd_d   = m_cnd_q;
        end else if (m_bubble) begin
            m_valid_d = 1'b0;
            m_cnd_d   = 1'b0;
        end else begin
            m_valid_d = e_valid;
            m_cnd_d   = e_cnd & e_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q      <= CC_RESET;
            m_valid_q <= 1'b0;
            m_cnd_q   <= 1'b0;
        end else begin
            cc_q      <= cc_d;
            m_valid_q <= m_valid_d;
            m_cnd_q   <= m_cnd_d;
        end
    end

    assign cc      = cc_q;
    assign M_cnd   = m_cnd_q;
    assign M_valid = m_valid_q;

`ifdef CC_PERF_EN
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_tk_q, perf_tk_d;
    logic        taken_ev;

    // Unconditional jumps/moves (ifun 0) are not counted as taken.
    assign taken_ev = m_load & e_valid & e_cnd & (e_ifun != COND_ALWAYS);

    always_comb begin
        perf_wr_d = perf_wr_q;
        perf_tk_d = perf_tk_q;
        if (cc_we && (perf_wr_q != 32'hFFFF_FFFF)) perf_wr_d = perf_wr_q + 32'd1;
        if (taken_ev && (perf_tk_q != 32'hFFFF_FFFF)) perf_tk_d = perf_tk_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_wr_q <= 32'd0;
            perf_tk_q <= 32'd0;
        end else begin
            perf_wr_q <= perf_wr_d;
            perf_tk_q <= perf_tk_d;
        end
    end

    assign perf_cc_writes = perf_wr_q;
    assign perf_cnd_taken = perf_tk_q;
`endif

endmodule

// File: tb/tb_y86_cc_cond_unit.sv
// Testbench for y86_cc_cond_unit: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural reference model.
module tb_y86_cc_cond_unit;

    logic        clk;
    logic        rst_n;
    logic        e_valid, e_set_cc;
    logic [3:0]  e_alufun, e_ifun;
    logic [63:0] e_vala, e_valb, e_valE;
    logic        m_stat_bad, w_stat_bad, m_stall, m_bubble;
    logic        e_cnd;
    logic [2:0]  cc;
    logic        M_cnd, M_valid;
`ifdef CC_PERF_EN
    logic [31:0] perf_cc_writes, perf_cnd_taken;
`endif

    y86_cc_cond_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .e_valid    (e_valid),
        .e_set_cc   (e_set_cc),
        .e_alufun   (e_alufun),
        .e_vala     (e_vala),
        .e_valb     (e_valb),
        .e_valE     (e_valE),
        .e_ifun     (e_ifun),
        .m_stat_bad (m_stat_bad),
        .w_stat_bad (w_stat_bad),
        .m_stall    (m_stall),
        .m_bubble   (m_bubble),
        .e_cnd      (e_cnd),
`ifdef CC_PERF_EN
        .perf_cc_writes (perf_cc_writes),
        .perf_cnd_taken (perf_cnd_taken),
`endif
        .cc         (cc),
        .M_cnd      (M_cnd),
        .M_valid    (M_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  cc;
        logic        mv;
        logic        mc;
        logic [31:0] pw;
        logic [31:0] pt;
    } seq_exp_t;

    logic     q_comb[$];
    seq_exp_t q_seq[$];

    // Reference architectural state
    logic        ref_zf, ref_sf, ref_of;
    logic        ref_mv, ref_mc;
    logic [31:0] ref_pw, ref_pt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        ref_zf = 1'b1; ref_sf = 1'b0; ref_of = 1'b0;
        ref_mv = 1'b0; ref_mc = 1'b0;
        ref_pw = 0;    ref_pt = 0;
    endtask

    // Branch conditions written as signed-comparison semantics after a compare.
    function automatic logic cond_ref(input logic zf, sf, of, input logic [3:0] ifn);
        logic less;
        less = (sf != of);
        case (ifn)
            4'd0: return 1'b1;
            4'd1: return less || zf;
            4'd2: return less;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !less;
            4'd6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Overflow as "the true signed result does not fit in 64 bits".
    function automatic logic ovf_ref(input logic [3:0] fn, input logic [63:0] a, b);
        logic signed [64:0] wide;
        if (fn == 4'd0) begin
            wide = $signed({a[63], a}) + $signed({b[63], b});
            return wide[64] != wide[63];
        end else if (fn == 4'd1) begin
            wide = $signed({b[63], b}) - $signed({a[63], a});
            return wide[64] != wide[63];
        end
        return 1'b0;
    endfunction

    task automatic drive(input logic v, sc, input logic [3:0] fn, input logic [63:0] a, b,
                         input logic [3:0] ifn, input logic mb, wb, st, bu);
        logic     exp_cnd;
        seq_exp_t s;
        @(negedge clk);
        e_valid = v; e_set_cc = sc; e_alufun = fn; e_vala = a; e_valb = b; e_ifun = ifn;
        m_stat_bad = mb; w_stat_bad = wb; m_stall = st; m_bubble = bu;
        case (fn)
            4'd0: e_valE = b + a;
            4'd1: e_valE = b - a;
            4'd2: e_valE = b & a;
            4'd3: e_valE = b ^ a;
            default: e_valE = {$urandom, $urandom};
        endcase
        #1;
        exp_cnd = cond_ref(ref_zf, ref_sf, ref_of, ifn);
        q_comb.push_back(exp_cnd);
        if (!st && !bu && v && exp_cnd && ifn != 4'd0 && ref_pt != 32'hFFFF_FFFF) ref_pt++;
        if (!st) begin
            ref_mv = bu ? 1'b0 : v;
            ref_mc = bu ? 1'b0 : (v && exp_cnd);
        end
        if (v && sc && !mb && !wb) begin
            ref_zf = (e_valE == 64'd0);
            ref_sf = e_valE[63];
            ref_of = ovf_ref(fn, a, b);
            if (ref_pw != 32'hFFFF_FFFF) ref_pw++;
        end
        s.cc = {ref_zf, ref_sf, ref_of};
        s.mv = ref_mv; s.mc = ref_mc; s.pw = ref_pw; s.pt = ref_pt;
        q_seq.push_back(s);
    endtask

    // Monitor: combinational condition, sampled after inputs settle.
    initial forever begin
        @(negedge clk);
        #2;
        if (q_comb.size() != 0) chk("e_cnd", e_cnd, q_comb.pop_front());
    end

    // Monitor: registered state, sampled shortly after the rising edge.
    initial forever begin
        seq_exp_t s;
        @(posedge clk);
        #1;
        if (q_seq.size() != 0) begin
            s = q_seq.pop_front();
            chk("cc", cc, s.cc);
            chk("M_valid", M_valid, s.mv);
            chk("M_cnd", M_cnd, s.mc);
`ifdef CC_PERF_EN
            chk("perf_cc_writes", perf_cc_writes, s.pw);
            chk("perf_cnd_taken", perf_cnd_taken, s.pt);
`endif
        end
    end

    function automatic logic [63:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return {60'd0, 4'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        e_valid = 0; e_set_cc = 0; e_alufun = 0; e_vala = 0; e_valb = 0; e_valE = 0;
        e_ifun = 0; m_stat_bad = 0; w_stat_bad = 0; m_stall = 0; m_bubble = 0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cc", cc, 3'b100);
        chk("reset_M_valid", M_valid, 1'b0);
        chk("reset_M_cnd", M_cnd, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add overflow: 7FFF..F + 7FFF..F -> negative, overflow
        drive(1, 1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0, 0, 0, 0, 0);
        drive(1, 0, 4'd0, 64'd0, 64'd0, 4'd2, 0, 0, 0, 0);
        chk("add_ovf_cc", cc, 3'b011);
        chk("add_ovf_jl", e_cnd, 1'b0);

        // XOR to zero, then je / jne
        drive(1, 1, 4'd3, 64'h1234, 64'h1234, 4'd0, 0, 0, 0, 0);
        drive(1, 0, 4'd0, 64'd0, 64'd0, 4'd3, 0, 0, 0, 0);
        chk("xor_zero_cc", cc, 3'b100);
        chk("xor_je", e_cnd, 1'b1);
        drive(1, 0, 4'd0, 64'd0, 64'd0, 4'd4, 0, 0, 0, 0);
        chk("xor_jne", e_cnd, 1'b0);
        chk("je_M_cnd", M_cnd, 1'b1);

        // Exception squash: sub 5-1 would clear ZF
        drive(1, 1, 4'd1, 64'd1, 64'd5, 4'd0, 1, 0, 0, 0);
        drive(0, 0, 4'd0, 64'd0, 64'd0, 4'd0, 0, 0, 0, 0);
        chk("squash_cc", cc, 3'b100);
        drive(1, 1, 4'd1, 64'd1, 64'd5, 4'd0, 0, 1, 0, 0);
        drive(0, 0, 4'd0, 64'd0, 64'd0, 4'd0, 0, 0, 0, 0);
        chk("squash_w_cc", cc, 3'b100);

        // Stall beats bubble, then bubble alone
        drive(1, 0, 4'd0, 64'd0, 64'd0, 4'd3, 0, 0, 0, 0);
        drive(0, 0, 4'd0, 64'd0, 64'd0, 4'd0, 0, 0, 1, 1);
        chk("pre_stall_M_valid", M_valid, 1'b1);
        drive(0, 0, 4'd0, 64'd0, 64'd0, 4'd0, 0, 0, 0, 1);
        chk("stall_hold_M_valid", M_valid, 1'b1);
        chk("stall_hold_M_cnd", M_cnd, 1'b1);
        drive(1, 0, 4'd0, 64'd0, 64'd0, 4'd9, 0, 0, 0, 0);
        chk("bubble_M_valid", M_valid, 1'b0);
        chk("bubble_M_cnd", M_cnd, 1'b0);
        chk("reserved_ifun9", e_cnd, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] fn;
            fn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            drive($urandom_range(0, 5) != 0, $urandom_range(0, 2) != 0, fn, pick_op(), pick_op(),
                  4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        // Make cc non-reset, then assert reset mid-cycle during a stall
        drive(1, 1, 4'd1, 64'd1, 64'd0, 4'd0, 0, 0, 0, 0);
        drive(1, 0, 4'd0, 64'd0, 64'd0, 4'd0, 0, 0, 0, 0);
        @(negedge clk);
        m_stall = 1'b1; e_valid = 1'b1; e_set_cc = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        ref_reset();
        chk("async_reset_cc", cc, 3'b100);
        chk("async_reset_M_valid", M_valid, 1'b0);
        chk("async_reset_M_cnd", M_cnd, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_hold_cc", cc, 3'b100);
        chk("reset_hold_M_valid", M_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 4'd0, 64'd0, 64'd0, 4'd3, 0, 0, 0, 0);
        drive(0, 0, 4'd0, 64'd0, 64'd0, 4'd0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #3;
        if (q_seq.size() != 0 || q_comb.size() != 0) begin
            chk("scoreboard_drained", q_seq.size() + q_comb.size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
